// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and helpers for the CDB write-back arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_INDEX_BIT = 5;   // ROB index width
  localparam int unsigned CDB_SRC_BIT   = 2;   // width of the winning-requester index
  localparam int unsigned CDB_REQ_MAX   = 4;   // largest supported requester count
  localparam int unsigned RESULT_W      = 32;  // broadcast result width
  localparam int unsigned FIFO_CNT_W    = 2;   // per-requester occupancy 0..2

  // Wrap an index that may exceed n-1 by less than n back into 0..n-1.
  function automatic logic [CDB_SRC_BIT-1:0] rr_wrap(input int unsigned idx,
                                                     input int unsigned n);
    int unsigned r;
    r = (idx >= n) ? (idx - n) : idx;
    return CDB_SRC_BIT'(r);
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Two-entry result buffer owned by one CDB requester.
//   clk_in, rst_n_in : clock, async active-low reset
//   push, pop, clear : write tail / drop head / empty the buffer (clear wins)
//   push_data        : entry written on push
//   head_c           : oldest entry (combinational from storage)
//   count            : registered occupancy 0..2
module cdb_req_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DW = ROB_INDEX_BIT + RESULT_W
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DW-1:0]         push_data,
  output logic [DW-1:0]         head_c,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  assign head_c = mem[rd_ptr];

  // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB write-back bus between N_REQ producers.
//   clk_in, rst_n_in  : clock, async active-low reset
//   rdy_in            : global stall (low freezes all state)
//   clear_in          : misprediction flush, empties buffers and resets rr_ptr
//   req_valid_in/req_rob_id_in/req_result_in/req_ready_out : per-requester push handshake
//   cdb_valid_out/cdb_rob_id_out/cdb_result_out/cdb_src_out : registered broadcast
//   pending_out       : per-buffer occupancy, 2 bits each
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned ROB_W = ROB_INDEX_BIT
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         clear_in,
  input  logic [N_REQ-1:0]             req_valid_in,
  input  logic [N_REQ*ROB_W-1:0]       req_rob_id_in,
  input  logic [N_REQ*RESULT_W-1:0]    req_result_in,
  output logic [N_REQ-1:0]             req_ready_out,
  output logic                         cdb_valid_out,
  output logic [ROB_W-1:0]             cdb_rob_id_out,
  output logic [RESULT_W-1:0]          cdb_result_out,
  output logic [CDB_SRC_BIT-1:0]       cdb_src_out,
  output logic [N_REQ*FIFO_CNT_W-1:0]  pending_out
);

  localparam int unsigned ENT_W = ROB_W + RESULT_W;

  logic                   active_c;
  logic [N_REQ-1:0]       push_c;
  logic [N_REQ-1:0]       pop_c;
  logic [N_REQ-1:0]       nonempty_c;
  logic [FIFO_CNT_W-1:0]  count [N_REQ];
  logic [ENT_W-1:0]       head_c [N_REQ];
  logic                   found_c;
  logic [CDB_SRC_BIT-1:0] winner_c;
  logic [ENT_W-1:0]       win_data_c;
  logic [CDB_SRC_BIT-1:0] rr_ptr;

  assign active_c = rdy_in && !clear_in;

  // Per-requester buffer; ready depends on registered count only, so a same-cycle pop never frees a slot.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_ready_out[gi] = active_c && (count[gi] != FIFO_CNT_W'(2));
    assign push_c[gi]        = req_valid_in[gi] && req_ready_out[gi];
    assign pop_c[gi]         = active_c && found_c && (winner_c == CDB_SRC_BIT'(gi));
    assign nonempty_c[gi]    = (count[gi] != '0);
    assign pending_out[gi*FIFO_CNT_W +: FIFO_CNT_W] = count[gi];

    cdb_req_fifo #(.DW(ENT_W)) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push      (push_c[gi]),
      .pop       (pop_c[gi]),
      .clear     (clear_in),
      .push_data ({req_rob_id_in[gi*ROB_W +: ROB_W], req_result_in[gi*RESULT_W +: RESULT_W]}),
      .head_c    (head_c[gi]),
      .count     (count[gi])
    );
  end

  // First non-empty buffer at or after rr_ptr, wrapping; entries pushed this edge are not yet visible.
  always_comb begin
    found_c    = 1'b0;
    winner_c   = '0;
    win_data_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found_c && nonempty_c[i] &&
            (rr_wrap(32'(rr_ptr) + k, N_REQ) == CDB_SRC_BIT'(i))) begin
          found_c    = 1'b1;
          winner_c   = CDB_SRC_BIT'(i);
          win_data_c = head_c[i];
        end
      end
    end
  end

  // Broadcast registers and round-robin pointer; data holds when nothing wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_out  <= 1'b0;
      cdb_rob_id_out <= '0;
      cdb_result_out <= '0;
      cdb_src_out    <= '0;
      rr_ptr         <= '0;
    end else if (clear_in) begin
      cdb_valid_out <= 1'b0;
      rr_ptr        <= '0;
    end else if (rdy_in) begin
      cdb_valid_out <= found_c;
      if (found_c) begin
        cdb_rob_id_out <= win_data_c[ENT_W-1 -: ROB_W];
        cdb_result_out <= win_data_c[RESULT_W-1:0];
        cdb_src_out    <= winner_c;
        rr_ptr         <= rr_wrap(32'(winner_c) + 32'd1, N_REQ);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-level model checked every cycle plus directed literal checks.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int RW = 5;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              rdy_in;
  logic              clear_in;
  logic [N-1:0]      req_valid_in;
  logic [N*RW-1:0]   req_rob_id_in;
  logic [N*32-1:0]   req_result_in;
  logic [N-1:0]      req_ready_out;
  logic              cdb_valid_out;
  logic [RW-1:0]     cdb_rob_id_out;
  logic [31:0]       cdb_result_out;
  logic [1:0]        cdb_src_out;
  logic [2*N-1:0]    pending_out;

  cdb_arbiter #(.N_REQ(N), .ROB_W(RW)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .req_valid_in   (req_valid_in),
    .req_rob_id_in  (req_rob_id_in),
    .req_result_in  (req_result_in),
    .req_ready_out  (req_ready_out),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_rob_id_out (cdb_rob_id_out),
    .cdb_result_out (cdb_result_out),
    .cdb_src_out    (cdb_src_out),
    .pending_out    (pending_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each buffer is an ordered list of entries, broadcast state is what was last granted.
  logic [RW+31:0] m_ent [N][2];
  int             m_cnt [N];
  int             m_rr;
  logic           m_valid;
  logic [RW-1:0]  m_rob;
  logic [31:0]    m_res;
  logic [1:0]     m_src;
  logic [N-1:0]   m_pushed;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr = 0; m_valid = 1'b0; m_rob = '0; m_res = '0; m_src = '0; m_pushed = '0;
  endtask

  task automatic model_edge();
    int pre [N];
    int win;
    m_pushed = '0;
    if (clear_in) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_valid = 1'b0;
      m_rr    = 0;
    end else if (rdy_in) begin
      for (int i = 0; i < N; i++) pre[i] = m_cnt[i];
      win = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (win < 0 && m_cnt[idx] > 0) win = idx;
      end
      if (win >= 0) begin
        m_valid = 1'b1;
        {m_rob, m_res} = m_ent[win][0];
        m_src = 2'(win);
        m_ent[win][0] = m_ent[win][1];
        m_cnt[win]--;
        m_rr = (win + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid_in[i] && pre[i] < 2) begin
          m_ent[i][m_cnt[i]] = {req_rob_id_in[i*RW +: RW], req_result_in[i*32 +: 32]};
          m_cnt[i]++;
          m_pushed[i] = 1'b1;
        end
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  logic [N-1:0]   e_rdy;
  logic [2*N-1:0] e_pend;
  always @(negedge clk_in) begin
    for (int i = 0; i < N; i++) begin
      e_rdy[i]          = rdy_in && !clear_in && (m_cnt[i] < 2);
      e_pend[2*i +: 2]  = 2'(m_cnt[i]);
    end
    chk("ready", 64'(req_ready_out), 64'(e_rdy));
    chk("pending", 64'(pending_out), 64'(e_pend));
    chk("cdb_valid", 64'(cdb_valid_out), 64'(m_valid));
    chk("cdb_payload", 64'({cdb_rob_id_out, cdb_result_out, cdb_src_out}),
        64'({m_rob, m_res, m_src}));
  end

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #2;
  endtask

  task automatic put(input int i, input logic [RW-1:0] rob, input logic [31:0] res);
    req_rob_id_in[i*RW +: RW] = rob;
    req_result_in[i*32 +: 32] = res;
  endtask

  task automatic chk_cdb(input string nm, input logic [1:0] src, input logic [31:0] res);
    chk({nm, "_valid"}, 64'(cdb_valid_out), 64'(1));
    chk({nm, "_src"}, 64'(cdb_src_out), 64'(src));
    chk({nm, "_result"}, 64'(cdb_result_out), 64'(res));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam int NI = 6;
  int   sent [N];
  int   got  [N];
  logic saw_full;

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    req_valid_in = '0; req_rob_id_in = '0; req_result_in = '0;
    model_reset();
    #12 rst_n_in = 1'b1;
    step();
    chk("reset_valid", 64'(cdb_valid_out), 64'(0));
    chk("reset_pending", 64'(pending_out), 64'(0));
    chk("reset_ready", 64'(req_ready_out), 64'(3'b111));
    chk("reset_payload", 64'({cdb_rob_id_out, cdb_result_out, cdb_src_out}), 64'(0));

    // Single push: visible on the CDB one edge after acceptance.
    put(0, 5'd5, 32'h11); req_valid_in = 3'b001;
    step();
    req_valid_in = '0;
    chk("single_pending", 64'(pending_out), 64'(6'b000001));
    chk("single_not_yet", 64'(cdb_valid_out), 64'(0));
    step();
    chk_cdb("single", 2'd0, 32'h11);
    chk("single_rob", 64'(cdb_rob_id_out), 64'(5));
    step();
    chk("single_pulse_end", 64'(cdb_valid_out), 64'(0));
    chk("single_hold", 64'(cdb_result_out), 64'(32'h11));

    // Contention from a cleared pointer: grants 0,1,2, pointer back at 0.
    clear_in = 1'b1; step(); clear_in = 1'b0;
    for (int i = 0; i < N; i++) put(i, 5'(10 + i), 32'h20 + 32'(i));
    req_valid_in = 3'b111;
    step();
    req_valid_in = '0;
    chk("cont_pending", 64'(pending_out), 64'(6'b010101));
    step(); chk_cdb("cont0", 2'd0, 32'h20);
    step(); chk_cdb("cont1", 2'd1, 32'h21);
    step(); chk_cdb("cont2", 2'd2, 32'h22);
    step(); chk("cont_idle", 64'(cdb_valid_out), 64'(0));
    put(0, 5'd1, 32'h50); put(2, 5'd3, 32'h52); req_valid_in = 3'b101;
    step(); req_valid_in = '0;
    step(); chk_cdb("rr_at0_a", 2'd0, 32'h50);
    step(); chk_cdb("rr_at0_b", 2'd2, 32'h52);
    step();

    // Back-pressure: all three stream, each valid held until the model says accepted.
    saw_full = 1'b0;
    for (int i = 0; i < N; i++) begin sent[i] = 0; got[i] = 0; end
    for (int c = 0; c < 80; c++) begin
      if (got[0] == NI && got[1] == NI && got[2] == NI) break;
      for (int i = 0; i < N; i++) begin
        req_valid_in[i] = (sent[i] < NI);
        put(i, 5'(i * 8 + sent[i]), 32'h1000 * 32'(i) + 32'(sent[i]));
      end
      step();
      for (int i = 0; i < N; i++) if (m_pushed[i]) sent[i]++;
      if (cdb_valid_out && cdb_src_out < 2'(N)) begin
        chk("stream_order", 64'(cdb_result_out),
            64'(32'h1000 * 32'(cdb_src_out) + 32'(got[cdb_src_out])));
        got[cdb_src_out]++;
      end
      if (pending_out[3:2] == 2'd2 && !req_ready_out[1]) saw_full = 1'b1;
    end
    req_valid_in = '0;
    for (int i = 0; i < N; i++) chk("stream_count", 64'(got[i]), 64'(NI));
    chk("stream_req1_full", 64'(saw_full), 64'(1));
    step(); step();

    // Flush with buffers loaded; that cycle's pushes are dropped.
    for (int i = 0; i < N; i++) put(i, 5'(i), 32'h60 + 32'(i));
    req_valid_in = 3'b111;
    step(); step(); step();
    clear_in = 1'b1;
    #1 chk("flush_ready_low", 64'(req_ready_out), 64'(0));
    step();
    clear_in = 1'b0; req_valid_in = '0;
    chk("flush_pending", 64'(pending_out), 64'(0));
    chk("flush_valid", 64'(cdb_valid_out), 64'(0));
    put(0, 5'd6, 32'h30); put(2, 5'd7, 32'h32); req_valid_in = 3'b101;
    step(); req_valid_in = '0;
    step(); chk_cdb("flush_first", 2'd0, 32'h30);
    step(); chk_cdb("flush_second", 2'd2, 32'h32);
    step();

    // Stall: three frozen cycles, req0's held valid accepted once rdy returns.
    for (int i = 0; i < N; i++) put(i, 5'(20 + i), 32'h40 + 32'(i));
    req_valid_in = 3'b111;
    step(); req_valid_in = '0;
    step(); chk_cdb("pre_stall", 2'd0, 32'h40);
    rdy_in = 1'b0; put(0, 5'd23, 32'h43); req_valid_in = 3'b001;
    #1 chk("stall_ready", 64'(req_ready_out), 64'(0));
    for (int s = 0; s < 3; s++) begin
      step();
      chk_cdb("stall_frozen", 2'd0, 32'h40);
      chk("stall_pending", 64'(pending_out), 64'(6'b010100));
    end
    rdy_in = 1'b1;
    step(); req_valid_in = '0;
    chk_cdb("resume1", 2'd1, 32'h41);
    chk("resume_pending", 64'(pending_out), 64'(6'b010001));
    step(); chk_cdb("resume2", 2'd2, 32'h42);
    step(); chk_cdb("resume3", 2'd0, 32'h43);
    step(); chk("resume_idle", 64'(cdb_valid_out), 64'(0));

    // Async reset between edges with four entries pending.
    for (int i = 0; i < N; i++) put(i, 5'(i), 32'h70 + 32'(i));
    req_valid_in = 3'b111;
    step();
    put(0, 5'd9, 32'h78); put(1, 5'd9, 32'h79); req_valid_in = 3'b011;
    step(); req_valid_in = '0;
    chk("prereset_pending", 64'(pending_out), 64'(6'b010110));
    chk_cdb("prereset", 2'd1, 32'h71);
    #1 rst_n_in = 1'b0; model_reset();
    #1;
    chk("areset_valid", 64'(cdb_valid_out), 64'(0));
    chk("areset_pending", 64'(pending_out), 64'(0));
    chk("areset_payload", 64'({cdb_rob_id_out, cdb_result_out, cdb_src_out}), 64'(0));
    chk("areset_ready", 64'(req_ready_out), 64'(3'b111));
    #2 rst_n_in = 1'b1;
    put(2, 5'd11, 32'h77); req_valid_in = 3'b100;
    step(); req_valid_in = '0;
    step(); chk_cdb("post_reset", 2'd2, 32'h77);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
